fdiv_pipe: RTL and testbench



---
 rtl/fdiv_pipe.sv | 176 +++++++++++++++++
 tb/tb_fdiv_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fdiv_pipe.sv
// fdiv_pipe: pipelined single-precision divider, y = x1 * finv(x2), 5-cycle latency.
// Ports: clk, rstn (async active-low), valid_in, x1, x2, tag_in -> valid_out, y, tag_out.
// finv: 3-stage reciprocal unit (no reset, no handshake), x in -> y three edges later.
// Ports: clk, x (divisor), y (registered reciprocal).

module finv (
    input  logic        clk,
    input  logic [31:0] x,
    output logic [31:0] y
);
    logic [31:0] x_q;
    logic [31:0] r_q;
    logic [31:0] recip;
    logic [48:0] num;
    logic [48:0] den;
    logic [48:0] qf;
    logic [25:0] q;
    logic signed [9:0] ex;
    logic [22:0] mant;
    logic unused_bits;

    // 2^48 / {1,m} lands in (2^24, 2^25]; bit 25 is set only for m == 0.
    always_comb begin
        num  = 49'h1_0000_0000_0000;
        den  = {25'b0, 1'b1, x_q[22:0]};
        qf   = num / den;
        q    = qf[25:0];
        ex   = 10'sd0;
        mant = 23'b0;
        if (q[25]) begin
            ex   = 10'sd254 - $signed({2'b0, x_q[30:23]});
            mant = q[24:2];
        end else begin
            ex   = 10'sd253 - $signed({2'b0, x_q[30:23]});
            mant = q[23:1];
        end
        if (ex <= 10'sd0) begin
            recip = {x_q[31], 31'b0};
        end else begin
            recip = {x_q[31], ex[7:0], mant};
        end
    end

    assign unused_bits = ^{qf[48:26], q[0]};

    always_ff @(posedge clk) begin
        x_q <= x;
        r_q <= recip;
        y   <= r_q;
    end
endmodule

module fdiv_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] tag_out
);
    logic [31:0] r;

    finv u_finv (
        .clk (clk),
        .x   (x2),
        .y   (r)
    );

    // Alignment stages A1..A3; index 2 lines up with finv's output.
    logic [2:0]             v_a;
    logic [2:0][31:0]       x1_a;
    logic [2:0][TAG_W-1:0]  tag_a;
    logic [2:0]             s2_a;
    logic [2:0]             z2_a;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_a   <= '0;
            x1_a  <= '0;
            tag_a <= '0;
            s2_a  <= '0;
            z2_a  <= '0;
        end else begin
            v_a   <= {v_a[1:0], valid_in};
            x1_a  <= {x1_a[1:0], x1};
            tag_a <= {tag_a[1:0], tag_in};
            s2_a  <= {s2_a[1:0], x2[31]};
            z2_a  <= {z2_a[1:0], (x2[30:23] == 8'd0)};
        end
    end

    // Stage M1: sign, biased exponent sum, mantissa product.
    logic [47:0]       ma;
    logic [47:0]       mb;
    logic [47:0]       p_n;
    logic signed [9:0] esum_n;
    logic unused_bits;

    assign ma     = {24'b0, 1'b1, x1_a[2][22:0]};
    assign mb     = {24'b0, 1'b1, r[22:0]};
    assign p_n    = ma * mb;
    assign esum_n = $signed({2'b0, x1_a[2][30:23]})
                  + $signed({2'b0, r[30:23]})
                  - 10'sd127;
    // Sign comes from the pipelined divisor; low product bits are truncated away.
    assign unused_bits = ^{r[31], p_n[22:0]};

    logic              v_m1;
    logic              s_m1;
    logic signed [9:0] esum_m1;
    logic [24:0]       p_m1;
    logic              z1_m1;
    logic              z2_m1;
    logic [TAG_W-1:0]  tag_m1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_m1    <= 1'b0;
            s_m1    <= 1'b0;
            esum_m1 <= '0;
            p_m1    <= '0;
            z1_m1   <= 1'b0;
            z2_m1   <= 1'b0;
            tag_m1  <= '0;
        end else begin
            v_m1    <= v_a[2];
            s_m1    <= x1_a[2][31] ^ s2_a[2];
            esum_m1 <= esum_n;
            p_m1    <= p_n[47:23];
            z1_m1   <= (x1_a[2][30:23] == 8'd0);
            z2_m1   <= z2_a[2];
            tag_m1  <= tag_a[2];
        end
    end

    // Stage M2: normalise by at most one place, truncate, apply special cases.
    logic signed [9:0] e_n;
    logic [22:0]       mant_n;
    logic [31:0]       y_n;

    always_comb begin
        e_n    = esum_m1;
        mant_n = p_m1[22:0];
        if (p_m1[24]) begin
            e_n    = esum_m1 + 10'sd1;
            mant_n = p_m1[23:1];
        end
        y_n = {s_m1, e_n[7:0], mant_n};
        if (z1_m1) begin
            y_n = {s_m1, 31'b0};
        end else if (z2_m1) begin
            y_n = {s_m1, 8'hFF, 23'b0};
        end else if (e_n >= 10'sd255) begin
            y_n = {s_m1, 8'hFF, 23'b0};
        end else if (e_n <= 10'sd0) begin
            y_n = {s_m1, 31'b0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            y         <= '0;
            tag_out   <= '0;
        end else begin
            valid_out <= v_m1;
            y         <= y_n;
            tag_out   <= tag_m1;
        end
    end
endmodule

// File: tb/tb_fdiv_pipe.sv
// tb_fdiv_pipe: scoreboard bench for fdiv_pipe.
// Driver pushes expected results; a monitor pops and compares on valid_out.

module tb_fdiv_pipe;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic [4:0]  tag_in = '0;
    logic        valid_out;
    logic [31:0] y;
    logic [4:0]  tag_out;

    fdiv_pipe #(.TAG_W(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .x1        (x1),
        .x2        (x2),
        .tag_in    (tag_in),
        .valid_out (valid_out),
        .y         (y),
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    always @(posedge clk) begin
        #1;
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_valid", {31'b0, valid_out}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y", y, e.y);
                check("tag", {27'b0, tag_out}, {27'b0, e.tag});
                check("latency", cyc - e.cyc, 32'd5);
            end
        end
    end

    function automatic logic [31:0] finv_m(input logic [31:0] x);
        int  e;
        int  ex;
        int  mant;
        real mr;
        real inv;
        e  = int'(x[30:23]);
        mr = 1.0 + real'(x[22:0]) / 8388608.0;
        inv = 1.0 / mr;
        if (inv == 1.0) begin
            ex = 254 - e;
            mant = 0;
        end else begin
            ex = 253 - e;
            mant = $rtoi((inv * 2.0 - 1.0) * 8388608.0);
        end
        if (ex <= 0) return {x[31], 31'b0};
        return {x[31], ex[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] fdiv_m(input logic [31:0] a,
                                           input logic [31:0] b);
        logic        s;
        logic [31:0] r;
        int  e;
        int  mant;
        real prod;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0) return {s, 31'b0};
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'b0};
        r = finv_m(b);
        prod = (1.0 + real'(a[22:0]) / 8388608.0)
             * (1.0 + real'(r[22:0]) / 8388608.0);
        e = int'(a[30:23]) + int'(r[30:23]) - 127;
        if (prod >= 2.0) begin
            prod = prod / 2.0;
            e = e + 1;
        end
        mant = $rtoi((prod - 1.0) * 8388608.0);
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) return {s, 31'b0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] ey);
        exp_t e;
        valid_in = 1'b1;
        x1 = a;
        x2 = b;
        tag_in = t;
        e.y = ey;
        e.tag = t;
        e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int k;
        valid_in = 1'b0;
        k = 0;
        while (sb.size() > 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, sb.size(), 32'd0);
        repeat (8) @(negedge clk);
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    logic [7:0]  ea;
    logic [7:0]  eb;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        check("reset_y", y, 32'd0);
        check("reset_tag", {27'b0, tag_out}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        issue(32'h40C0_0000, 32'h4000_0000, 5'd3, 32'h4040_0000);
        issue(32'h3F80_0000, 32'h4080_0000, 5'd4, 32'h3E80_0000);
        issue(32'hBF80_0000, 32'h3E80_0000, 5'd5, 32'hC080_0000);
        issue(32'hBF80_0000, 32'h0000_0000, 5'd6, 32'hFF80_0000);
        issue(32'h0000_0000, 32'h4000_0000, 5'd7, 32'h0000_0000);
        issue(32'h8000_0000, 32'h3F80_0000, 5'd8, 32'h8000_0000);
        issue(32'h7F00_0000, 32'h3E80_0000, 5'd9, 32'h7F80_0000);
        issue(32'h0080_0000, 32'h4080_0000, 5'd10, 32'h0000_0000);
        drain("drain_directed");

        for (int i = 0; i < 20; i++) begin
            ea = 8'($urandom_range(100, 154));
            eb = 8'($urandom_range(100, 154));
            ra = {1'($urandom), ea, 23'($urandom)};
            rb = {1'($urandom), eb, 23'($urandom)};
            issue(ra, rb, 5'(i), fdiv_m(ra, rb));
        end
        drain("drain_stream");

        issue(32'h40C0_0000, 32'h4000_0000, 5'd1, 32'h4040_0000);
        issue(32'h3F80_0000, 32'h4080_0000, 5'd2, 32'h3E80_0000);
        issue(32'hBF80_0000, 32'h3E80_0000, 5'd3, 32'hC080_0000);
        valid_in = 1'b0;
        rstn = 1'b0;
        sb.delete();
        #1;
        check("midreset_valid", {31'b0, valid_out}, 32'd0);
        check("midreset_y", y, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        issue(32'h4100_0000, 32'h4000_0000, 5'd17, 32'h4080_0000);
        drain("drain_post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
